// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the RV32I 5-stage core: load-use stalls,
// EX-resolved redirects with multi-cycle fetch flush, data-memory freezes.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             EN_PC,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             NOP_Ins,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Redirect cycle itself is the first flush cycle, FLUSH covers the rest.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] fcnt_q;
    logic [2:0] fcnt_d;
    logic       hz;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       stall_inc;
    logic       flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
        hz      = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= INIT;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        EN_PC       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        NOP_Ins     = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (rst) begin
            EN_PC       = 1'b0;
            if_id_en    = 1'b0;
            NOP_Ins     = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = INIT;
            fcnt_d      = 3'd0;
        end else begin
            case (state_q)
                INIT: begin
                    EN_PC       = 1'b0;
                    if_id_en    = 1'b0;
                    NOP_Ins     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = RUN;
                end

                RUN: begin
                    if (mem_busy) begin
                        // Freeze, not bubble: pending redirect/hazard is retried once busy drops.
                        EN_PC     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        stall_inc = 1'b1;
                    end else if (ex_redirect) begin
                        NOP_Ins     = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FLUSH_LOAD;
                        end
                    end else if (hz) begin
                        EN_PC     = 1'b0;
                        if_id_en  = 1'b0;
                        NOP_Ins   = 1'b1;
                        stall_inc = 1'b1;
                    end
                end

                FLUSH: begin
                    NOP_Ins     = 1'b1;
                    if_id_flush = 1'b1;
                    if (mem_busy) begin
                        EN_PC     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        stall_inc = 1'b1;
                    end else begin
                        flush_inc = 1'b1;
                        if (fcnt_q <= 3'd1) begin
                            state_d = RUN;
                            fcnt_d  = 3'd0;
                        end else begin
                            fcnt_d = fcnt_q - 3'd1;
                        end
                    end
                end

                default: begin
                    state_d = INIT;
                    fcnt_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: three instances (FLUSH_CYCLES 3/2/1, CNT_W 16/16/4)
// driven in parallel and compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_is_load = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       mem_busy = 1'b0;

    logic en_pc[3], if_id_en[3], id_ex_en[3], nop_ins[3], if_id_flush[3], id_ex_flush[3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;

    logic [5:0]  obs_out[3];
    logic [15:0] obs_stall[3];
    logic [15:0] obs_flush[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_a (
        .CLK(CLK), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .EN_PC(en_pc[0]), .if_id_en(if_id_en[0]), .id_ex_en(id_ex_en[0]),
        .NOP_Ins(nop_ins[0]), .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]),
        .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
        .CLK(CLK), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .EN_PC(en_pc[1]), .if_id_en(if_id_en[1]), .id_ex_en(id_ex_en[1]),
        .NOP_Ins(nop_ins[1]), .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_c (
        .CLK(CLK), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .EN_PC(en_pc[2]), .if_id_en(if_id_en[2]), .id_ex_en(id_ex_en[2]),
        .NOP_Ins(nop_ins[2]), .if_id_flush(if_id_flush[2]), .id_ex_flush(id_ex_flush[2]),
        .stall_cnt(sc2), .flush_cnt(fc2));

    always_comb begin
        for (int i = 0; i < 3; i++)
            obs_out[i] = {en_pc[i], if_id_en[i], id_ex_en[i], nop_ins[i], if_id_flush[i], id_ex_flush[i]};
        obs_stall[0] = sc0;
        obs_stall[1] = sc1;
        obs_stall[2] = {12'd0, sc2};
        obs_flush[0] = fc0;
        obs_flush[1] = fc1;
        obs_flush[2] = {12'd0, fc2};
    end

    // Reference model: flush cycles still owed, init pending, counter values.
    int fcyc[3] = '{3, 2, 1};
    int cmax[3] = '{65535, 65535, 15};
    int m_init[3] = '{1, 1, 1};
    int m_fl[3]   = '{0, 0, 0};
    int m_st[3]   = '{0, 0, 0};
    int m_fc[3]   = '{0, 0, 0};
    int n_init[3] = '{1, 1, 1};
    int n_fl[3]   = '{0, 0, 0};
    int n_st[3]   = '{0, 0, 0};
    int n_fc[3]   = '{0, 0, 0};
    logic [5:0]  e_out[3];
    logic [15:0] e_stall[3];
    logic [15:0] e_flush[3];

    // Output vector order: {EN_PC, if_id_en, id_ex_en, NOP_Ins, if_id_flush, id_ex_flush}
    task automatic drive(input logic r, input logic b, input logic red, input logic ld,
                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2);
        logic hz;
        for (int i = 0; i < 3; i++) begin
            m_init[i] = n_init[i];
            m_fl[i]   = n_fl[i];
            m_st[i]   = n_st[i];
            m_fc[i]   = n_fc[i];
        end
        @(negedge CLK);
        rst = r; mem_busy = b; ex_redirect = red; ex_is_load = ld;
        ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        #1;
        cyc++;
        hz = ld && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        for (int i = 0; i < 3; i++) begin
            e_stall[i] = 16'(m_st[i]);
            e_flush[i] = 16'(m_fc[i]);
            n_init[i] = m_init[i]; n_fl[i] = m_fl[i]; n_st[i] = m_st[i]; n_fc[i] = m_fc[i];
            if (r) begin
                e_out[i] = 6'b001111;
                n_init[i] = 1; n_fl[i] = 0; n_st[i] = 0; n_fc[i] = 0;
            end else if (m_init[i] != 0) begin
                e_out[i] = 6'b001111;
                n_init[i] = 0;
            end else if (m_fl[i] > 0) begin
                if (b) begin
                    e_out[i] = 6'b000110;
                    n_st[i] = (m_st[i] >= cmax[i]) ? m_st[i] : m_st[i] + 1;
                end else begin
                    e_out[i] = 6'b111110;
                    n_fc[i] = (m_fc[i] >= cmax[i]) ? m_fc[i] : m_fc[i] + 1;
                    n_fl[i] = m_fl[i] - 1;
                end
            end else if (b) begin
                e_out[i] = 6'b000000;
                n_st[i] = (m_st[i] >= cmax[i]) ? m_st[i] : m_st[i] + 1;
            end else if (red) begin
                e_out[i] = 6'b111111;
                n_fc[i] = (m_fc[i] >= cmax[i]) ? m_fc[i] : m_fc[i] + 1;
                n_fl[i] = fcyc[i] - 1;
            end else if (hz) begin
                e_out[i] = 6'b001100;
                n_st[i] = (m_st[i] >= cmax[i]) ? m_st[i] : m_st[i] + 1;
            end else begin
                e_out[i] = 6'b111000;
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            else idle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL reset_out dut%0d cyc%0d got %b want %b", i, cyc, obs_out[i], e_out[i]);
                end
                checks++;
                if (obs_stall[i] !== 16'd0 || obs_flush[i] !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_cnt dut%0d cyc%0d got %0d/%0d want 0/0", i, cyc, obs_stall[i], obs_flush[i]);
                end
            end
        end
        checks++;
        if (en_pc[0] !== 1'b1 || nop_ins[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got EN_PC=%b NOP_Ins=%b want 1/0", en_pc[0], nop_ins[0]);
        end
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
                3: drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
                4: drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0);
                default: idle();
            endcase
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL load_use_out dut%0d cyc%0d got %b want %b", i, cyc, obs_out[i], e_out[i]);
                end
                checks++;
                if (obs_stall[i] !== e_stall[i]) begin
                    errors++;
                    $display("FAIL load_use_stall dut%0d cyc%0d got %0d want %0d", i, cyc, obs_stall[i], e_stall[i]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int nflush = 0;
        int nidf = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            else idle();
            if (if_id_flush[0] === 1'b1) nflush++;
            if (id_ex_flush[0] === 1'b1) nidf++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i] || obs_flush[i] !== e_flush[i]) begin
                    errors++;
                    $display("FAIL redirect dut%0d cyc%0d got %b/%0d want %b/%0d",
                             i, cyc, obs_out[i], obs_flush[i], e_out[i], e_flush[i]);
                end
            end
        end
        checks++;
        if (nflush != 3 || nidf != 1) begin
            errors++;
            $display("FAIL redirect_len got if_id_flush=%0d id_ex_flush=%0d want 3/1", nflush, nidf);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 7; k++) begin
            if (k < 2) drive(0, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
            else if (k == 2) drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
            else idle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL simult_out dut%0d cyc%0d got %b want %b", i, cyc, obs_out[i], e_out[i]);
                end
                checks++;
                if (obs_stall[i] !== e_stall[i] || obs_flush[i] !== e_flush[i]) begin
                    errors++;
                    $display("FAIL simult_cnt dut%0d cyc%0d got %0d/%0d want %0d/%0d",
                             i, cyc, obs_stall[i], obs_flush[i], e_stall[i], e_flush[i]);
                end
            end
        end
    endtask

    task automatic test_busy_in_flush();
        logic [15:0] s0, f0;
        drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        idle();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            else if (k <= 3) drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            else idle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL busy_flush_out dut%0d cyc%0d got %b want %b", i, cyc, obs_out[i], e_out[i]);
                end
                checks++;
                if (obs_stall[i] !== e_stall[i] || obs_flush[i] !== e_flush[i]) begin
                    errors++;
                    $display("FAIL busy_flush_cnt dut%0d cyc%0d got %0d/%0d want %0d/%0d",
                             i, cyc, obs_stall[i], obs_flush[i], e_stall[i], e_flush[i]);
                end
            end
        end
        s0 = obs_stall[1];
        f0 = obs_flush[1];
        checks++;
        if (s0 !== 16'd3 || f0 !== 16'd2) begin
            errors++;
            $display("FAIL busy_flush_total got stall=%0d flush=%0d want 3/2", s0, f0);
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i] || obs_stall[i] !== e_stall[i]) begin
                    errors++;
                    $display("FAIL saturation dut%0d cyc%0d got %b/%0d want %b/%0d",
                             i, cyc, obs_out[i], obs_stall[i], e_out[i], e_stall[i]);
                end
            end
        end
        idle();
        checks++;
        if (obs_stall[2] !== 16'd15 || obs_stall[0] !== 16'd20) begin
            errors++;
            $display("FAIL saturation_final got %0d/%0d want 15/20", obs_stall[2], obs_stall[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_out[i] !== e_out[i]) begin
                    errors++;
                    $display("FAIL random_out dut%0d cyc%0d got %b want %b", i, cyc, obs_out[i], e_out[i]);
                end
                checks++;
                if (obs_stall[i] !== e_stall[i] || obs_flush[i] !== e_flush[i]) begin
                    errors++;
                    $display("FAIL random_cnt dut%0d cyc%0d got %0d/%0d want %0d/%0d",
                             i, cyc, obs_stall[i], obs_flush[i], e_stall[i], e_flush[i]);
                end
                checks++;
                if (en_pc[i] === 1'b0 && if_id_en[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL invariant dut%0d cyc%0d got if_id_en=%b want 0 when EN_PC=0", i, cyc, if_id_en[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_simultaneous();
        test_busy_in_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
